// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: compares operands, computes the next PC, trains a
// table of 2-bit direction counters and keeps branch/mispredict statistics.
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_num1,
  input  logic [XLEN-1:0]  in_num2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [2:0]       in_br_type,
  input  logic             in_pred_taken,
  input  logic             flush,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             lk_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [XLEN-1:0]  out_target,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [2:0] {
    BR_BEQ    = 3'd0,
    BR_BNE    = 3'd1,
    BR_BLT    = 3'd2,
    BR_BGE    = 3'd3,
    BR_BLTU   = 3'd4,
    BR_BGEU   = 3'd5,
    BR_ALWAYS = 3'd6,
    BR_NEVER  = 3'd7
  } br_type_e;

  logic             out_valid_q, out_valid_d;
  logic             out_taken_q, out_mispredict_q;
  logic [XLEN-1:0]  out_target_q;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_entry_d;

  logic             taken_d, mispredict_d, accept, cond_br;
  logic [XLEN-1:0]  target_d;
  logic [IDX_W-1:0] up_idx, lk_idx;

  // Index drops the two byte-offset bits; the cast truncates to the table size.
  assign up_idx   = IDX_W'(in_pc >> 2);
  assign lk_idx   = IDX_W'(lk_pc >> 2);
  assign lk_taken = bht_q[lk_idx][1];

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;
  assign cond_br  = ~(in_br_type[2] & in_br_type[1]);

  always_comb begin
    taken_d = 1'b0;
    case (br_type_e'(in_br_type))
      BR_BEQ:    taken_d = (in_num1 == in_num2);
      BR_BNE:    taken_d = (in_num1 != in_num2);
      BR_BLT:    taken_d = ($signed(in_num1) < $signed(in_num2));
      BR_BGE:    taken_d = ~($signed(in_num1) < $signed(in_num2));
      BR_BLTU:   taken_d = (in_num1 < in_num2);
      BR_BGEU:   taken_d = ~(in_num1 < in_num2);
      BR_ALWAYS: taken_d = 1'b1;
      BR_NEVER:  taken_d = 1'b0;
      default:   taken_d = 1'b0;
    endcase
  end

  assign target_d     = taken_d ? (in_pc + in_imm) : (in_pc + XLEN'(4));
  assign mispredict_d = taken_d ^ in_pred_taken;

  always_comb begin
    bht_entry_d = bht_q[up_idx];
    if (taken_d) begin
      if (bht_q[up_idx] != 2'b11) bht_entry_d = bht_q[up_idx] + 2'b01;
    end else begin
      if (bht_q[up_idx] != 2'b00) bht_entry_d = bht_q[up_idx] - 2'b01;
    end
  end

  always_comb begin
    out_valid_d      = out_valid_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (flush) out_valid_d = 1'b0;
    else if (accept) out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    if (accept) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispredict_d && (mispredict_cnt_q != '1))
        mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_mispredict_q <= 1'b0;
      out_target_q     <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      out_valid_q      <= out_valid_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      if (accept) begin
        out_taken_q      <= taken_d;
        out_mispredict_q <= mispredict_d;
        out_target_q     <= target_d;
      end
      // Unconditional types carry no direction information worth learning.
      if (accept && cond_br) bht_q[up_idx] <= bht_entry_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_taken      = out_taken_q;
  assign out_mispredict = out_mispredict_q;
  assign out_target     = out_target_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: behavioural reference checked every cycle,
// plus directed scenarios with literal expected values.
module tb_branch_resolve_unit;
  localparam int XLEN  = 32;
  localparam int BHT   = 64;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [XLEN-1:0] in_pc = '0, in_num1 = '0, in_num2 = '0, in_imm = '0;
  logic [2:0] in_br_type = 3'd0;
  logic in_pred_taken = 1'b0, flush = 1'b0;
  logic [XLEN-1:0] lk_pc = '0;
  logic lk_taken, out_valid, out_taken, out_mispredict;
  logic out_ready = 1'b1;
  logic [XLEN-1:0] out_target;
  logic [CNT_W-1:0] branch_cnt, mispredict_cnt;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(BHT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_num1(in_num1), .in_num2(in_num2), .in_imm(in_imm),
    .in_br_type(in_br_type), .in_pred_taken(in_pred_taken), .flush(flush),
    .lk_pc(lk_pc), .lk_taken(lk_taken), .out_valid(out_valid),
    .out_ready(out_ready), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_target(out_target),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome rules and counter behaviour in plain arithmetic.
  int m_bht [BHT];
  bit m_valid, m_taken, m_mis;
  logic [XLEN-1:0] m_target;
  int m_bcnt, m_mcnt;
  bit started = 0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic bit outcome(input int t, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    int sa, sb;
    sa = a; sb = b;
    if (t == 0) return a == b;
    if (t == 1) return a != b;
    if (t == 2) return sa < sb;
    if (t == 3) return sa >= sb;
    if (t == 4) return a < b;
    if (t == 5) return a >= b;
    return t == 6;
  endfunction

  function automatic int bidx(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % BHT);
  endfunction

  always @(posedge clk) begin
    bit rdy, tk;
    int ix;
    started = 1;
    if (rst) begin
      m_valid = 0; m_taken = 0; m_mis = 0; m_target = '0;
      m_bcnt = 0; m_mcnt = 0;
      for (int i = 0; i < BHT; i++) m_bht[i] = 1;
    end else begin
      rdy = !m_valid || out_ready;
      if (flush) m_valid = 0;
      else if (in_valid && rdy) begin
        tk = outcome(int'(in_br_type), in_num1, in_num2);
        m_taken = tk;
        m_mis = tk != in_pred_taken;
        m_target = tk ? in_pc + in_imm : in_pc + 32'd4;
        m_valid = 1;
        if (in_br_type < 6) begin
          ix = bidx(in_pc);
          m_bht[ix] = tk ? ((m_bht[ix] + 1 > 3) ? 3 : m_bht[ix] + 1)
                         : ((m_bht[ix] - 1 < 0) ? 0 : m_bht[ix] - 1);
        end
        if (m_bcnt < CNT_MAX) m_bcnt++;
        if (m_mis && m_mcnt < CNT_MAX) m_mcnt++;
      end else if (out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", in_ready, (!m_valid || out_ready));
      check("out_valid", out_valid, m_valid);
      check("branch_cnt", branch_cnt, m_bcnt);
      check("mispredict_cnt", mispredict_cnt, m_mcnt);
      check("lk_taken", lk_taken, m_bht[bidx(lk_pc)] >= 2);
      if (m_valid) begin
        check("out_taken", out_taken, m_taken);
        check("out_mispredict", out_mispredict, m_mis);
        check("out_target", out_target, m_target);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic lk_at_send;

  task automatic send(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                      input logic [2:0] t, input logic pred);
    in_valid = 1; in_pc = pc; in_num1 = a; in_num2 = b; in_imm = imm;
    in_br_type = t; in_pred_taken = pred;
    #1 lk_at_send = lk_taken;
    cyc();
    in_valid = 0;
  endtask

  initial begin
    // Reset held with a live request and flush: nothing may be accepted.
    in_valid = 1; in_br_type = 3'd6; flush = 1;
    repeat (3) cyc();
    in_valid = 0; flush = 0; out_ready = 0; rst = 0;
    cyc();
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_target", out_target, 0);
    check("reset branch_cnt", branch_cnt, 0);
    check("reset lk_taken", lk_taken, 0);
    out_ready = 1;

    send(32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 3'd2, 0);
    check("blt taken", out_taken, 1);
    check("blt target", out_target, 32'h120);
    check("blt mispredict", out_mispredict, 1);
    check("blt mis_cnt", mispredict_cnt, 1);

    send(32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 3'd4, 0);
    check("bltu taken", out_taken, 0);
    check("bltu target", out_target, 32'h104);
    check("bltu mispredict", out_mispredict, 0);
    check("bltu branch_cnt", branch_cnt, 2);

    lk_pc = 32'h40;
    send(32'h40, 32'h5, 32'h5, 32'h8, 3'd0, 1);
    check("bht lk 1st", lk_at_send, 0);
    send(32'h40, 32'h5, 32'h5, 32'h8, 3'd0, 1);
    check("bht lk 2nd", lk_at_send, 1);
    send(32'h40, 32'h5, 32'h5, 32'h8, 3'd0, 1);
    check("bht lk 3rd", lk_at_send, 1);
    send(32'h40, 32'h5, 32'h5, 32'h8, 3'd0, 1);
    send(32'h40, 32'h5, 32'h6, 32'h8, 3'd0, 1);
    check("bht after sat+nt", lk_taken, 1);
    send(32'h40, 32'h5, 32'h6, 32'h8, 3'd0, 0);
    check("bht after 2nd nt", lk_taken, 0);
    check("mis_cnt after bht", mispredict_cnt, 2);

    // Backpressure: result A held while B waits.
    send(32'h200, 32'h3, 32'hFFFF_FFFF, 32'h10, 3'd3, 1);
    check("bge target", out_target, 32'h210);
    out_ready = 0;
    in_valid = 1; in_pc = 32'h300; in_num1 = 32'h3; in_num2 = 32'hFFFF_FFFF;
    in_imm = 32'h10; in_br_type = 3'd5; in_pred_taken = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall in_ready", in_ready, 0);
      check("stall target", out_target, 32'h210);
    end
    out_ready = 1;
    cyc();
    in_valid = 0;
    check("bgeu target", out_target, 32'h304);
    check("bgeu branch_cnt", branch_cnt, 10);

    // Flush with a pending result and a live request.
    out_ready = 0; flush = 1; in_valid = 1;
    in_pc = 32'h40; in_num1 = 32'h7; in_num2 = 32'h7; in_br_type = 3'd0;
    cyc();
    flush = 0; in_valid = 0;
    check("flush out_valid", out_valid, 0);
    check("flush branch_cnt", branch_cnt, 10);
    check("flush mis_cnt", mispredict_cnt, 2);
    check("flush lk_taken", lk_taken, 0);
    out_ready = 1;

    lk_pc = 32'hFFFF_FFF0;
    send(32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 3'd6, 1);
    check("wrap target", out_target, 32'h10);
    check("wrap taken", out_taken, 1);
    check("wrap lk_taken", lk_taken, 0);

    send(32'h80, 32'h1, 32'h2, 32'h40, 3'd1, 0);
    check("bne target", out_target, 32'hC0);
    send(32'h80, 32'h1, 32'h2, 32'h40, 3'd7, 1);
    check("never target", out_target, 32'h84);
    check("never mispredict", out_mispredict, 1);
    for (int i = 0; i < 4; i++) send(32'h84, 32'h9, 32'h2, 32'h8, 3'd2, 0);
    check("branch_cnt saturated", branch_cnt, 4'hF);

    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      in_pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      in_num1 = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFE : 32'($urandom_range(0, 5));
      in_num2 = 32'($urandom_range(0, 5));
      in_imm = 32'($urandom_range(0, 255)) - 32'd128;
      in_br_type = 3'($urandom_range(0, 7));
      in_pred_taken = 1'($urandom_range(0, 1));
      lk_pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      cyc();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
